mccoy_acc_core_p: RTL and testbench
===================================

Name: mccoy_acc_core_p

Overview:
Parametrised successor to the McCoy accumulator core. Single-issue accumulator machine with a configurable register file and data/PC widths. Executes one externally supplied instruction per clock: the instruction source, either the pin wrapper or a small ROM, drives `instr` for the address on `pc`. Adds SUB/logic/shift ops, BNZ, a carry flag, a valid-based stall and a HALT/resume state machine. The legacy 3-bit opcodes are kept binary-compatible when `instr[3]`=0.

Parameters:
DATA_W, 8, accumulator/register width (>=4)
NREGS, 8, register count, power of 2; REG_W = clog2(NREGS)
IMM_W, 3, immediate/operand field width (>= REG_W)
PC_W, 6, program counter width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
instr  in  IMM_W+4  {imm[IMM_W-1:0], opcode[3:0]}
instr_valid  in  1  instr is valid this cycle; 0 = stall
resume  in  1  leave HALT (sampled only in HALT)
pc  out  PC_W  address of instruction to execute
acc  out  DATA_W  accumulator
carry  out  1  carry/borrow flag
halted  out  1  1 while in HALT state

Behaviour:
- Reset (sampled at clk edge, overrides everything, including mid-HALT): pc=0, acc=0, carry=0, all regs=0, state=RUN, halted=0.
- States: RUN, HALT. In RUN with instr_valid=1, execute one instruction per cycle; results are visible on the next edge (latency 1). With instr_valid=0, all state holds.
- Operand r = reg[imm[REG_W-1:0]]; immediate zero-extended to DATA_W for LI; branch offset = imm sign-extended to PC_W.
- Default next pc = pc+1, wrapping mod 2^PC_W.
- Opcodes:
 0000 BEZ: if acc==0, pc <= pc+sext(imm), else pc+1
 0001 LI: acc <= zext(imm)
 0010 BNZ: if acc!=0, pc <= pc+sext(imm), else pc+1
 0011 ADD: {carry,acc} <= acc+r (DATA_W+1-bit sum)
 0100 LR: acc <= r
 0101 SUB: {carry,acc} <= acc-r; carry=1 means borrow (acc<r unsigned)
 0110 SR: reg[idx] <= acc
 0111 AND: acc <= acc & r
 1000 XOR: acc <= acc ^ r
 1001 SHL: {carry,acc} <= {acc,0}
 1010 SHR: {acc,carry} <= {0,acc}
 1011 HALT: state <= HALT, pc unchanged
 others: NOP, pc+1
- carry changes only on ADD/SUB/SHL/SHR. Other ops hold it.
- Branch offset 0 is a self-loop. Negative offsets wrap below 0 to the top of the PC range.
- SR followed by LR of the same register on the next cycle must read the new value (register write lands at the edge; no bypass needed since execution is 1 cycle).
- HALT: halted=1; instr and instr_valid are ignored. When resume=1, the next edge sets state=RUN and pc <= pc+1. If reset and resume are both asserted, reset wins.
- If IMM_W > REG_W, upper imm bits are ignored for register ops.

Test Plan:
1. Default params, reset, then LI 3; SR x2; LI 4; ADD x2 -> acc=7, carry=0, pc=4; LR x2 -> acc=3.
2. LI 7; SR x1; SHL x4 -> acc=0x70, carry=0; SHL -> acc=0xE0; ADD x0 (0) -> acc unchanged; LI 7; ADD r with 0xFF stored -> acc=0x06, carry=1.
3. LI 0; SUB x1 where x1=1 -> acc=0xFF, carry=1; BNZ imm=3'b110 (-2) at pc=10 -> pc=8; BEZ same with acc!=0 -> pc+1.
4. Drive pc to 63, NOP -> pc=0. BEZ with offset -1 at pc=0 and acc=0 -> pc=63.
5. Hold instr_valid=0 for 3 cycles with ADD on instr -> acc, pc, carry unchanged; HALT -> halted=1, pc frozen for 5 cycles under random instr; resume -> halted=0, pc+1.
6. Reset asserted during HALT with resume=1 -> pc=0, acc=0, halted=0. Rerun scenario 1 with DATA_W=16, NREGS=16, IMM_W=5 -> same results, and reg index 12 is accessible.

Source files
------------

// File: rtl/mccoy_acc_core_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : mccoy_acc_core_p_if
//  Brief    : Instruction-fetch / architectural-state bundle between the
//             McCoy accumulator core and its instruction source.
//  Revision : 1.0  initial parametrised release
// ============================================================================
interface mccoy_acc_core_p_if #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 3,
  parameter int PC_W   = 6
);
  logic [IMM_W+3:0]  instr;        // {imm, opcode}
  logic              instr_valid;  // 0 stalls the core
  logic              resume;       // leave HALT
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic              halted;

  // Instruction source side (pin wrapper, ROM or testbench)
  modport master (
    output instr, instr_valid, resume,
    input  pc, acc, carry, halted
  );

  // Core side
  modport slave (
    input  instr, instr_valid, resume,
    output pc, acc, carry, halted
  );
endinterface
`default_nettype wire

// File: rtl/mccoy_acc_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : mccoy_acc_core_p
//  Brief    : Parametrised single-issue accumulator machine. Executes one
//             externally supplied instruction per clock, with register file,
//             carry flag, conditional branches, valid-based stall and a
//             HALT/resume state machine. Opcodes with instr[3]=0 keep the
//             legacy 3-bit encoding.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module mccoy_acc_core_p #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 3,
  parameter int PC_W   = 6
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mccoy_acc_core_p_if.slave  bus
);

  localparam int REG_W = $clog2(NREGS);

  localparam logic [3:0] OP_BEZ  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_BNZ  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_LR   = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SR   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Architectural state
  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                reg_we_d;

  // Instruction decode
  logic [3:0]          w_op;
  logic [IMM_W-1:0]    w_imm;
  logic [REG_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_r;
  logic [PC_W-1:0]     w_off;
  logic [DATA_W-1:0]   w_imm_zx;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_pc_br;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;

  assign w_op  = bus.instr[3:0];
  assign w_imm = bus.instr[IMM_W+3:4];
  // Upper immediate bits beyond the register index are don't-care for register ops
  assign w_idx = w_imm[REG_W-1:0];
  assign w_r   = regs_q[w_idx];

  // Branch offset: immediate sign-extended (or truncated) to the PC width
  generate
    if (PC_W > IMM_W) begin : g_sext_wide
      assign w_off = {{(PC_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    end else begin : g_sext_narrow
      assign w_off = w_imm[PC_W-1:0];
    end
  endgenerate

  // LI operand: immediate zero-extended (or truncated) to the data width
  generate
    if (DATA_W > IMM_W) begin : g_zext_wide
      assign w_imm_zx = {{(DATA_W-IMM_W){1'b0}}, w_imm};
    end else begin : g_zext_narrow
      assign w_imm_zx = w_imm[DATA_W-1:0];
    end
  endgenerate

  // PC arithmetic wraps naturally modulo 2^PC_W
  assign w_pc_inc = pc_q + c_PC_ONE;
  assign w_pc_br  = pc_q + w_off;

  // One extra bit captures carry-out of ADD and borrow of SUB
  assign w_sum  = {1'b0, acc_q} + {1'b0, w_r};
  assign w_diff = {1'b0, acc_q} - {1'b0, w_r};

  // Next-state logic: instruction execution in RUN, resume handling in HALT
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    reg_we_d = 1'b0;

    if (state_q == ST_HALT) begin
      // instr/instr_valid are ignored here; only resume matters
      if (bus.resume) begin
        state_d = ST_RUN;
        pc_d    = w_pc_inc;
      end
    end else if (bus.instr_valid) begin
      pc_d = w_pc_inc;
      case (w_op)
        OP_BEZ:  if (acc_q == '0) pc_d = w_pc_br;
        OP_LI:   acc_d = w_imm_zx;
        OP_BNZ:  if (acc_q != '0) pc_d = w_pc_br;
        OP_ADD:  {carry_d, acc_d} = w_sum;
        OP_LR:   acc_d = w_r;
        OP_SUB:  {carry_d, acc_d} = w_diff;
        OP_SR:   reg_we_d = 1'b1;
        OP_AND:  acc_d = acc_q & w_r;
        OP_XOR:  acc_d = acc_q ^ w_r;
        OP_SHL:  {carry_d, acc_d} = {acc_q, 1'b0};
        OP_SHR:  {acc_d, carry_d} = {1'b0, acc_q};
        OP_HALT: begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
        default: ;  // unassigned opcodes behave as NOP
      endcase
    end
  end

  // State, PC, accumulator and carry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // Register file: SR writes land at the edge so a following LR sees them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we_d) begin
      regs_q[w_idx] <= acc_q;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.acc    = acc_q;
  assign bus.carry  = carry_q;
  assign bus.halted = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mccoy_acc_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mccoy_acc_core_p
//  Brief    : Scoreboard bench for mccoy_acc_core_p. Two instances: default
//             parameters and a wide variant (DATA_W=16, NREGS=16, IMM_W=5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mccoy_acc_core_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mccoy_acc_core_p_if #(.DATA_W(8),  .IMM_W(3), .PC_W(6)) bus0 ();
  mccoy_acc_core_p_if #(.DATA_W(16), .IMM_W(5), .PC_W(6)) bus1 ();

  mccoy_acc_core_p #(.DATA_W(8), .NREGS(8), .IMM_W(3), .PC_W(6)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mccoy_acc_core_p #(.DATA_W(16), .NREGS(16), .IMM_W(5), .PC_W(6)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // Opcodes as a programmer sees them
  localparam int BEZ = 0, LI = 1, BNZ = 2, ADD = 3, LR = 4, SUB = 5, SR = 6;
  localparam int SHL = 9, HALT = 11, NOP = 12;

  typedef struct {
    int          k;
    int          id;
    int unsigned pc;
    int unsigned acc;
    int unsigned carry;
    int unsigned halted;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  // Reference machine state, one per instance
  int unsigned m_pc   [2];
  int unsigned m_acc  [2];
  int unsigned m_carry[2];
  int unsigned m_halt [2];
  int unsigned m_regs [2][16];

  task automatic chk(string nm, int id, int unsigned got, int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, got, exp);
    end
  endtask

  // Architectural behaviour described from the instruction-set rules
  function automatic void model_step(int k, int unsigned ins, bit v, bit res, bit rst);
    int unsigned dw   = (k == 0) ? 8 : 16;
    int unsigned nr   = (k == 0) ? 8 : 16;
    int unsigned iw   = (k == 0) ? 3 : 5;
    int unsigned mask = (1 << dw) - 1;
    int unsigned op   = ins & 15;
    int unsigned imm  = (ins >> 4) & ((1 << iw) - 1);
    int unsigned r    = m_regs[k][imm % nr];
    int          off  = (imm >= (1 << (iw - 1))) ? int'(imm) - (1 << iw) : int'(imm);
    int unsigned br   = (m_pc[k] + off) & 63;
    int unsigned inc  = (m_pc[k] + 1) & 63;
    int unsigned s;
    if (rst) begin
      m_pc[k] = 0; m_acc[k] = 0; m_carry[k] = 0; m_halt[k] = 0;
      for (int i = 0; i < 16; i++) m_regs[k][i] = 0;
      return;
    end
    if (m_halt[k] != 0) begin
      if (res) begin
        m_halt[k] = 0;
        m_pc[k]   = inc;
      end
      return;
    end
    if (!v) return;
    m_pc[k] = inc;
    case (op)
      0:  if (m_acc[k] == 0) m_pc[k] = br;
      1:  m_acc[k] = imm & mask;
      2:  if (m_acc[k] != 0) m_pc[k] = br;
      3:  begin s = m_acc[k] + r; m_acc[k] = s & mask; m_carry[k] = s >> dw; end
      4:  m_acc[k] = r;
      5:  begin m_carry[k] = (m_acc[k] < r) ? 1 : 0; m_acc[k] = (m_acc[k] - r) & mask; end
      6:  m_regs[k][imm % nr] = m_acc[k];
      7:  m_acc[k] = m_acc[k] & r;
      8:  m_acc[k] = m_acc[k] ^ r;
      9:  begin m_carry[k] = (m_acc[k] >> (dw - 1)) & 1; m_acc[k] = (m_acc[k] << 1) & mask; end
      10: begin m_carry[k] = m_acc[k] & 1; m_acc[k] = m_acc[k] >> 1; end
      11: begin m_halt[k] = 1; m_pc[k] = m_pc[k] - 1 & 63; m_pc[k] = (inc + 63) & 63; end
      default: ;
    endcase
  endfunction

  // Drive one cycle on instance k (the other idles), predict, then queue the prediction
  task automatic step(int k, int unsigned ins, bit v, bit res, bit rst);
    exp_t e;
    bus0.instr       = (k == 0) ? ins[6:0] : 7'd0;
    bus0.instr_valid = (k == 0) ? v : 1'b0;
    bus0.resume      = (k == 0) ? res : 1'b0;
    bus1.instr       = (k == 1) ? ins[8:0] : 9'd0;
    bus1.instr_valid = (k == 1) ? v : 1'b0;
    bus1.resume      = (k == 1) ? res : 1'b0;
    reset            = rst;
    model_step(0, (k == 0) ? ins : 0, (k == 0) && v, (k == 0) && res, rst);
    model_step(1, (k == 1) ? ins : 0, (k == 1) && v, (k == 1) && res, rst);
    step_id++;
    e.k = k; e.id = step_id;
    e.pc = m_pc[k]; e.acc = m_acc[k]; e.carry = m_carry[k]; e.halted = m_halt[k];
    @(posedge clk);
    q.push_back(e);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(int k, int op, int imm);
    step(k, (imm << 4) | op, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare the queued prediction with the DUT away from the clock edge
  exp_t        mon_e;
  int unsigned a_pc, a_acc, a_carry, a_halt;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.k == 0) begin
        a_pc = bus0.pc; a_acc = bus0.acc; a_carry = bus0.carry; a_halt = bus0.halted;
      end else begin
        a_pc = bus1.pc; a_acc = bus1.acc; a_carry = bus1.carry; a_halt = bus1.halted;
      end
      chk(mon_e.k == 0 ? "pc0"     : "pc1",     mon_e.id, a_pc,    mon_e.pc);
      chk(mon_e.k == 0 ? "acc0"    : "acc1",    mon_e.id, a_acc,   mon_e.acc);
      chk(mon_e.k == 0 ? "carry0"  : "carry1",  mon_e.id, a_carry, mon_e.carry);
      chk(mon_e.k == 0 ? "halted0" : "halted1", mon_e.id, a_halt,  mon_e.halted);
    end
  end

  initial begin
    int guard;
    bus0.instr = '0; bus0.instr_valid = 1'b0; bus0.resume = 1'b0;
    bus1.instr = '0; bus1.instr_valid = 1'b0; bus1.resume = 1'b0;

    // Reset and basic arithmetic on the default instance
    step(0, 0, 1'b0, 1'b0, 1'b1);
    run(0, LI, 3); run(0, SR, 2); run(0, LI, 4); run(0, ADD, 2);
    chk("s1_acc", step_id, bus0.acc, 7);
    chk("s1_pc",  step_id, bus0.pc, 4);
    run(0, LR, 2);
    chk("s1_lr",  step_id, bus0.acc, 3);

    // Shifts, carry-out of ADD, borrow of SUB
    run(0, LI, 7); run(0, SR, 1);
    for (int i = 0; i < 4; i++) run(0, SHL, 0);
    chk("s2_shl4", step_id, bus0.acc, 8'h70);
    run(0, SHL, 0); run(0, ADD, 0);
    chk("s2_shl5", step_id, bus0.acc, 8'hE0);
    run(0, LI, 1); run(0, SR, 1); run(0, LI, 0); run(0, SUB, 1);
    chk("s3_sub",  step_id, bus0.acc, 8'hFF);
    chk("s3_borrow", step_id, bus0.carry, 1);
    run(0, SR, 3); run(0, LI, 7); run(0, ADD, 3);
    chk("s2_add_acc",   step_id, bus0.acc, 8'h06);
    chk("s2_add_carry", step_id, bus0.carry, 1);
    run(0, BNZ, 6);
    chk("s3_bnz", step_id, bus0.pc, 18);
    run(0, BEZ, 6);
    chk("s3_bez_nt", step_id, bus0.pc, 19);

    // PC wrap both directions
    guard = 0;
    while (m_pc[0] != 63 && guard < 70) begin run(0, NOP, 0); guard++; end
    run(0, LI, 0);
    chk("s4_wrap", step_id, bus0.pc, 0);
    run(0, BEZ, 7);
    chk("s4_neg", step_id, bus0.pc, 63);

    // Stall, halt under noise, resume
    for (int i = 0; i < 3; i++) step(0, (3 << 4) | ADD, 1'b0, 1'b0, 1'b0);
    run(0, HALT, 0);
    chk("s5_halted", step_id, bus0.halted, 1);
    for (int i = 0; i < 5; i++) step(0, $urandom & 32'h7F, 1'($urandom), 1'b0, 1'b0);
    chk("s5_frozen", step_id, bus0.pc, 63);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    chk("s5_resume", step_id, bus0.halted, 0);
    chk("s5_pc",     step_id, bus0.pc, 0);

    // Reset beats resume while halted
    run(0, LI, 5); run(0, HALT, 0);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    chk("s6_rst_pc",  step_id, bus0.pc, 0);
    chk("s6_rst_acc", step_id, bus0.acc, 0);
    chk("s6_rst_hlt", step_id, bus0.halted, 0);

    // Random programs on the default instance
    for (int i = 0; i < 300; i++)
      step(0, $urandom & 32'h7F, ($urandom % 5) != 0, ($urandom % 3) == 0, ($urandom % 97) == 0);

    // Wide instance: scenario 1 again plus high register index
    step(1, 0, 1'b0, 1'b0, 1'b1);
    run(1, LI, 3); run(1, SR, 2); run(1, LI, 4); run(1, ADD, 2);
    chk("w_acc", step_id, bus1.acc, 7);
    chk("w_pc",  step_id, bus1.pc, 4);
    run(1, LR, 2);
    chk("w_lr",  step_id, bus1.acc, 3);
    run(1, LI, 21); run(1, SR, 12); run(1, LI, 0); run(1, LR, 12);
    chk("w_r12", step_id, bus1.acc, 21);
    for (int i = 0; i < 200; i++)
      step(1, $urandom & 32'h1FF, ($urandom % 5) != 0, ($urandom % 3) == 0, ($urandom % 97) == 0);

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (q.size() > 0 && guard < 5) begin @(posedge clk); guard++; end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
